map_scheduler: RTL and testbench
================================

# map_scheduler

Front-end sequencer for the constellation mapper. It collects bytes from an upstream handshake stream into one 64-bit mapper word per 8-subcarrier group, sized by a run-time modulation select. It pulses the mapper's clock enable and tracks the mapper's one-cycle output latency with a valid/last flag toward the IFFT loader. It counts groups per OFDM symbol and zero-pads a symbol when the data ends early.

## Interface
- NUM_GROUPS, 8: 8-subcarrier groups per OFDM symbol (≥1; counter width $clog2(NUM_GROUPS+1)).
- clk  in  1  single clock, all logic on posedge.
- rst_n  in  1  synchronous active-low reset.
- sym_start  in  1  one-cycle request to begin a symbol; ignored unless idle.
- mod_sel  in  3  0 BPSK, 1 QPSK, 2 QAM16, 3 QAM64, 4 QAM256; sampled only with an accepted sym_start.
- in_data  in  8  payload byte.
- in_valid  in  1  byte present.
- in_last  in  1  qualifies the final payload byte of the symbol.
- in_ready  out  1  byte accepted when in_valid && in_ready.
- map_data  out  64  mapper input word; byte n of group in bits [8n+7:8n]; unused upper bytes 0.
- map_en  out  1  mapper clock enable, one cycle per group.
- map_mod  out  3  latched modulation for the current symbol.
- map_valid  out  1  mapper outputs hold a valid group.
- map_last  out  1  with map_valid: last group of the symbol.
- out_ready  in  1  downstream consumes the group when map_valid && out_ready.
- busy  out  1  state ≠ IDLE.
- err  out  1  sticky: an unsupported mod_sel (5–7) was latched.

## Operation
- Bytes per group k: 1, 2, 4, 6, 8 for mod 0–4. Unsupported mod_sel latches as 0 (BPSK) and sets err. err clears only on reset.
- States:
  - IDLE: sym_start → FILL. Latches map_mod, clears byte count, group count and pad flag.
  - FILL: in_ready = !pad && (byte_cnt < k). Each accepted byte is written into byte lane byte_cnt of the assembly register and byte_cnt is incremented.
    - in_last accepted → pad = 1.
    - While pad = 1, one zero byte is written per cycle without consuming input.
    - byte_cnt reaching k → ISSUE.
  - ISSUE: map_en = (!map_valid || out_ready), combinational from state and flags.
    - When map_en = 1, the group counter increments and byte_cnt is cleared.
    - Next state is FILL, or DRAIN if this was group NUM_GROUPS.
  - DRAIN: waits for the final group to be consumed (map_valid && out_ready), then → IDLE.
- Lanes at index k and above, and all lanes when map_en = 0, are driven 0 in map_data. map_data is stable whenever map_en = 1.
- Assembly register is cleared at each group start, so lanes never carry stale data.
- map_valid:
  - Set the cycle after map_en.
  - Cleared when consumed with no concurrent map_en.
  - Stays 1 if consume and map_en coincide.
- map_last is registered with map_valid: 1 for the group issued as group NUM_GROUPS.
- in_last at the end of the final group produces no padding. Bytes beyond NUM_GROUPS·k are not accepted: in_ready = 0 outside FILL.
- in_last mid-group: the rest of that group and all remaining groups are zero-filled, and NUM_GROUPS groups are still issued.
- sym_start while busy is ignored. A new sym_start is honoured in the cycle IDLE is re-entered's successor, i.e. once busy = 0.

## Timing
- Reset values: in_ready 0, map_en 0, map_data 0, map_mod 0, map_valid 0, map_last 0, busy 0, err 0; state IDLE.
- Reset mid-symbol aborts immediately. Mapper outputs are then masked by map_valid = 0.
- Symbol start:
  - sym_start at cycle 0 → busy = 1 and in_ready = 1 at cycle 1.
  - With in_valid held high, the first map_en comes at cycle 1+k and map_valid at cycle 2+k.
- Throughput with no stalls: k+1 cycles per group; the ISSUE cycle accepts no input.
- Backpressure:
  - out_ready = 0 with map_valid = 1 holds ISSUE, so map_en stays 0 and mapper outputs freeze.
  - out_ready returning to 1 allows map_en in that same cycle.
- DRAIN exits the cycle after the last consume. busy = 0 from the following cycle.

## Test plan
- QPSK, NUM_GROUPS=2, bytes 0xA5,0x3C,0x01,0x80, out_ready = 1:
  - map_en at cycles 3 and 6.
  - map_data = 0x3CA5 then 0x8001.
  - map_last only with the second map_valid; busy falls after.
- QAM64, bytes 0x11..0x66: map_data = 0x0000_6655_4433_2211, then one map_en, map_mod = 3.
- QAM16, NUM_GROUPS=3, in_last on byte 2 (0xFF,0xEE):
  - Group 1 = 0x0000EEFF, groups 2–3 = 0.
  - in_ready stays 0 after in_last; exactly 3 map_en.
- BPSK with out_ready = 0 for 5 cycles while map_valid = 1:
  - No map_en and map_valid held during the stall.
  - Issue resumes the cycle out_ready rises; no group lost or duplicated.
- mod_sel = 6: err = 1, map_mod = 0, 1 byte per group. err persists through later symbols until rst_n = 0.
- Reset mid-symbol (QAM256, after 3 bytes): all outputs at reset values next cycle. A new sym_start then runs a clean symbol with no carry-over bytes.

Source files
------------

// File: rtl/map_scheduler.sv
// Byte-to-group sequencer ahead of the constellation mapper: packs k bytes per 8-subcarrier group,
// pulses the mapper enable, tracks its one-cycle output latency and zero-pads short symbols.
module map_scheduler #(
  parameter int NUM_GROUPS = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sym_start,
  input  logic [2:0]  mod_sel,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  output logic [63:0] map_data,
  output logic        map_en,
  output logic [2:0]  map_mod,
  output logic        map_valid,
  output logic        map_last,
  input  logic        out_ready,
  output logic        busy,
  output logic        err
);

  localparam int GW = $clog2(NUM_GROUPS + 1);

  typedef enum logic [1:0] {IDLE, FILL, ISSUE, DRAIN} state_t;

  state_t         state;
  logic [3:0]     byte_cnt;
  logic [3:0]     k;
  logic [GW-1:0]  grp_cnt;
  logic           pad;
  logic [63:0]    asm_q;
  logic [63:0]    lane_mask;
  logic           accept;
  logic           wr;
  logic           last_grp;

  always_comb begin
    case (map_mod)
      3'd0:    k = 4'd1;
      3'd1:    k = 4'd2;
      3'd2:    k = 4'd4;
      3'd3:    k = 4'd6;
      3'd4:    k = 4'd8;
      default: k = 4'd1;
    endcase
  end

  always_comb begin
    lane_mask = '0;
    for (int n = 0; n < 8; n++) begin
      if (4'(n) < k) lane_mask[8*n +: 8] = 8'hFF;
    end
  end

  assign in_ready = (state == FILL) && !pad && (byte_cnt < k);
  assign accept   = in_valid && in_ready;
  // Once padding starts, a zero byte goes in every FILL cycle without touching the input stream.
  assign wr       = (state == FILL) && (pad || accept);
  assign map_en   = (state == ISSUE) && (!map_valid || out_ready);
  assign last_grp = (grp_cnt == GW'(NUM_GROUPS - 1));
  assign map_data = map_en ? (asm_q & lane_mask) : '0;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      byte_cnt  <= '0;
      grp_cnt   <= '0;
      pad       <= 1'b0;
      asm_q     <= '0;
      map_mod   <= '0;
      map_valid <= 1'b0;
      map_last  <= 1'b0;
      err       <= 1'b0;
    end else begin
      if (map_en) begin
        map_valid <= 1'b1;
        map_last  <= last_grp;
      end else if (map_valid && out_ready) begin
        map_valid <= 1'b0;
        map_last  <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (sym_start) begin
            state    <= FILL;
            map_mod  <= (mod_sel > 3'd4) ? 3'd0 : mod_sel;
            if (mod_sel > 3'd4) err <= 1'b1;
            byte_cnt <= '0;
            grp_cnt  <= '0;
            pad      <= 1'b0;
            asm_q    <= '0;
          end
        end
        FILL: begin
          if (wr) begin
            asm_q[{byte_cnt[2:0], 3'b000} +: 8] <= pad ? 8'h00 : in_data;
            byte_cnt <= byte_cnt + 4'd1;
            if (accept && in_last) pad <= 1'b1;
            if (byte_cnt + 4'd1 == k) state <= ISSUE;
          end
        end
        ISSUE: begin
          if (map_en) begin
            grp_cnt  <= grp_cnt + 1'b1;
            byte_cnt <= '0;
            asm_q    <= '0;
            state    <= last_grp ? DRAIN : FILL;
          end
        end
        DRAIN: begin
          if (map_valid && out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_map_scheduler.sv
// Bench for map_scheduler: directed scenarios plus randomized symbols against a byte-array model.
module tb_map_scheduler;

  localparam int NG = 3;

  logic        clk = 1'b0;
  logic        rst_n, sym_start, in_valid, in_last, out_ready;
  logic [2:0]  mod_sel;
  logic [7:0]  in_data;
  logic        in_ready, map_en, map_valid, map_last, busy, err;
  logic [63:0] map_data;
  logic [2:0]  map_mod;

  map_scheduler #(.NUM_GROUPS(NG)) dut (
    .clk(clk), .rst_n(rst_n), .sym_start(sym_start), .mod_sel(mod_sel),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .map_data(map_data), .map_en(map_en), .map_mod(map_mod), .map_valid(map_valid),
    .map_last(map_last), .out_ready(out_ready), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]  pl[$];
  logic [63:0] q_grp[$];
  logic        q_last[$];
  int          q_en_cyc[$];
  logic [2:0]  q_mod[$];
  int          n_acc, fall_cyc, pad_viol, stall_bad;
  logic        b1, r1, resume_en, timed_out;

  function automatic int kof(input logic [2:0] m);
    case (m)
      3'd1: return 2;
      3'd2: return 4;
      3'd3: return 6;
      3'd4: return 8;
      default: return 1;
    endcase
  endfunction

  // Model: the symbol is a flat byte array of NG*k slots, payload first, zeros after.
  function automatic logic [63:0] exp_grp(input int g, input int k);
    logic [63:0] w = '0;
    for (int b = 0; b < k; b++)
      if (g * k + b < pl.size()) w[8*b +: 8] = pl[g * k + b];
    return w;
  endfunction

  task automatic run_symbol(input logic [2:0] m, input int pv, input int pr, input bit stall);
    int cyc = 0, idx = 0, stall_left = 0;
    bit done = 0, lastacc = 0, stalled = 0, resume = 0;
    q_grp.delete(); q_last.delete(); q_en_cyc.delete(); q_mod.delete();
    pad_viol = 0; stall_bad = 0; resume_en = 1'b0; fall_cyc = -1;
    @(posedge clk); #1;
    sym_start = 1'b1; mod_sel = m; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    while (!done && cyc < 3000) begin
      @(posedge clk); #1;
      cyc++;
      sym_start = 1'b0;
      mod_sel   = 3'($urandom);
      in_valid  = (idx < pl.size()) && ($urandom_range(99) < pv);
      in_data   = in_valid ? pl[idx] : 8'($urandom);
      in_last   = in_valid && (idx == pl.size() - 1);
      if (stall && !stalled && map_valid) begin
        stalled = 1; stall_left = 5;
      end
      out_ready = (stall_left > 0) ? 1'b0 : ($urandom_range(99) < pr);
      @(negedge clk);
      if (cyc == 1) begin b1 = busy; r1 = in_ready; end
      if (lastacc && in_ready) pad_viol++;
      if (in_valid && in_ready) begin
        if (in_last) lastacc = 1;
        idx++;
      end
      if (map_en) begin
        q_grp.push_back(map_data); q_en_cyc.push_back(cyc); q_mod.push_back(map_mod);
      end
      if (map_valid && out_ready) q_last.push_back(map_last);
      if (stall_left > 0) begin
        if (map_en || !map_valid) stall_bad++;
        stall_left--;
        if (stall_left == 0) resume = 1;
      end else if (resume) begin
        resume = 0; resume_en = map_en;
      end
      if (!busy) begin done = 1; fall_cyc = cyc; end
    end
    timed_out = !done;
    n_acc = idx;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; sym_start = 1'b0; mod_sel = '0; in_data = '0;
    in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({in_ready, map_en, map_data, map_mod, map_valid, map_last, busy, err} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got rdy=%b en=%b data=%h mod=%0d vld=%b last=%b busy=%b err=%b, required all 0",
               in_ready, map_en, map_data, map_mod, map_valid, map_last, busy, err);
    end
  endtask

  task automatic test_qpsk_timing;
    pl = '{8'hA5, 8'h3C, 8'h01, 8'h80, 8'h5A, 8'hC3};
    run_symbol(3'd1, 100, 100, 0);
    n_tests++;
    if (timed_out !== 1'b0 || b1 !== 1'b1 || r1 !== 1'b1) begin
      n_fail++; $display("FAIL qpsk_start: timeout=%b busy1=%b ready1=%b, required 0 1 1", timed_out, b1, r1);
    end
    n_tests++;
    if (q_en_cyc.size() != NG) begin
      n_fail++; $display("FAIL qpsk_en_count: got %0d, required %0d", q_en_cyc.size(), NG);
    end else begin
      for (int g = 0; g < NG; g++) begin
        n_tests++;
        if (q_en_cyc[g] != 3 + 3 * g) begin
          n_fail++; $display("FAIL qpsk_en_cycle[%0d]: got %0d, required %0d", g, q_en_cyc[g], 3 + 3 * g);
        end
        n_tests++;
        if (q_grp[g] !== exp_grp(g, 2)) begin
          n_fail++; $display("FAIL qpsk_data[%0d]: got %h, required %h", g, q_grp[g], exp_grp(g, 2));
        end
      end
      n_tests++;
      if (fall_cyc != q_en_cyc[NG-1] + 2) begin
        n_fail++; $display("FAIL qpsk_busy_fall: got cycle %0d, required %0d", fall_cyc, q_en_cyc[NG-1] + 2);
      end
    end
    n_tests++;
    if (q_last.size() != NG || q_last[0] !== 1'b0 || q_last[1] !== 1'b0 || q_last[2] !== 1'b1) begin
      n_fail++; $display("FAIL qpsk_last: got %p, required '{0,0,1}", q_last);
    end
  endtask

  task automatic test_qam64;
    pl = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    for (int i = 0; i < 12; i++) pl.push_back(8'($urandom));
    run_symbol(3'd3, 100, 100, 0);
    n_tests++;
    if (q_grp.size() != NG || q_grp[0] !== 64'h0000_6655_4433_2211 || q_mod[0] !== 3'd3) begin
      n_fail++; $display("FAIL qam64_group0: got n=%0d data=%h mod=%0d, required n=%0d 0000665544332211 mod=3",
                         q_grp.size(), q_grp.size() ? q_grp[0] : 64'h0, q_mod.size() ? q_mod[0] : 3'd0, NG);
    end
  endtask

  task automatic test_pad;
    pl = '{8'hFF, 8'hEE};
    run_symbol(3'd2, 100, 100, 0);
    n_tests++;
    if (q_grp.size() != NG || timed_out) begin
      n_fail++; $display("FAIL pad_en_count: got %0d map_en, required %0d", q_grp.size(), NG);
    end else begin
      n_tests++;
      if (q_grp[0] !== 64'h0000_0000_0000_EEFF || q_grp[1] !== '0 || q_grp[2] !== '0) begin
        n_fail++; $display("FAIL pad_data: got %h %h %h, required 000000000000eeff 0 0", q_grp[0], q_grp[1], q_grp[2]);
      end
      n_tests++;
      if (q_en_cyc[0] != 5 || q_en_cyc[1] != 10 || q_en_cyc[2] != 15) begin
        n_fail++; $display("FAIL pad_en_cycles: got %0d %0d %0d, required 5 10 15", q_en_cyc[0], q_en_cyc[1], q_en_cyc[2]);
      end
    end
    n_tests++;
    if (pad_viol != 0 || n_acc != 2) begin
      n_fail++; $display("FAIL pad_ready: got %0d ready-after-last cycles, %0d bytes taken, required 0 and 2", pad_viol, n_acc);
    end
  endtask

  task automatic test_stall;
    pl = '{8'h5D, 8'h9E, 8'h27};
    run_symbol(3'd0, 100, 100, 1);
    n_tests++;
    if (stall_bad != 0 || resume_en !== 1'b1) begin
      n_fail++; $display("FAIL stall_hold: got %0d bad stall cycles, resume map_en=%b, required 0 and 1", stall_bad, resume_en);
    end
    n_tests++;
    if (q_grp.size() != NG || q_grp[0] !== exp_grp(0, 1) || q_grp[1] !== exp_grp(1, 1) || q_grp[2] !== exp_grp(2, 1)) begin
      n_fail++; $display("FAIL stall_groups: got %p, required %h %h %h", q_grp, exp_grp(0, 1), exp_grp(1, 1), exp_grp(2, 1));
    end
  endtask

  task automatic test_err;
    bit bad = 0;
    pl = '{8'h12, 8'h34, 8'h56, 8'h78};
    run_symbol(3'd6, 100, 100, 0);
    for (int g = 0; g < q_grp.size(); g++) if (q_grp[g] !== exp_grp(g, 1) || q_mod[g] !== 3'd0) bad = 1;
    n_tests++;
    if (err !== 1'b1 || bad || q_grp.size() != NG) begin
      n_fail++; $display("FAIL err_latch: got err=%b groups=%p mods=%p, required err=1 BPSK groups mod 0", err, q_grp, q_mod);
    end
    for (int i = 0; i < 8; i++) pl.push_back(8'($urandom));
    run_symbol(3'd2, 100, 100, 0);
    n_tests++;
    if (err !== 1'b1 || q_grp.size() != NG || q_grp[NG-1] !== exp_grp(NG - 1, 4)) begin
      n_fail++; $display("FAIL err_sticky: got err=%b n=%0d, required err=1 n=%0d", err, q_grp.size(), NG);
    end
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    n_tests++;
    if (err !== 1'b0) begin
      n_fail++; $display("FAIL err_clear: got %b, required 0", err);
    end
  endtask

  task automatic test_reset_mid;
    bit bad = 0;
    @(posedge clk); #1 sym_start = 1'b1; mod_sel = 3'd4; out_ready = 1'b1;
    @(posedge clk); #1 sym_start = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = 8'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({in_ready, map_en, map_data, map_mod, map_valid, map_last, busy, err} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid: got rdy=%b en=%b data=%h mod=%0d vld=%b last=%b busy=%b err=%b, required all 0",
               in_ready, map_en, map_data, map_mod, map_valid, map_last, busy, err);
    end
    pl.delete();
    for (int i = 0; i < 8 * NG; i++) pl.push_back(8'($urandom));
    run_symbol(3'd4, 100, 100, 0);
    for (int g = 0; g < q_grp.size(); g++) if (q_grp[g] !== exp_grp(g, 8)) bad = 1;
    n_tests++;
    if (bad || q_grp.size() != NG || timed_out) begin
      n_fail++; $display("FAIL reset_clean_symbol: got %p, required fresh QAM256 groups", q_grp);
    end
  endtask

  task automatic test_random;
    for (int s = 0; s < 30; s++) begin
      logic [2:0] m;
      int k, len, bad_g;
      m = 3'($urandom_range(7));
      k = kof(m);
      len = $urandom_range(NG * k + 3, 1);
      pl.delete();
      for (int i = 0; i < len; i++) pl.push_back(8'($urandom));
      run_symbol(m, $urandom_range(100, 30), $urandom_range(100, 20), 0);
      bad_g = 0;
      for (int g = 0; g < q_grp.size(); g++)
        if (q_grp[g] !== exp_grp(g, k) || q_mod[g] !== ((m > 3'd4) ? 3'd0 : m)) bad_g++;
      n_tests++;
      if (timed_out || q_grp.size() != NG || bad_g != 0) begin
        n_fail++; $display("FAIL rand_groups[%0d]: mod=%0d len=%0d timeout=%b n=%0d bad=%0d, required n=%0d bad=0",
                           s, m, len, timed_out, q_grp.size(), bad_g, NG);
      end
      n_tests++;
      if (n_acc != ((len < NG * k) ? len : NG * k) || pad_viol != 0) begin
        n_fail++; $display("FAIL rand_accept[%0d]: got %0d bytes, %0d pad violations, required %0d and 0",
                           s, n_acc, pad_viol, (len < NG * k) ? len : NG * k);
      end
      n_tests++;
      if (q_last.size() != NG || q_last[NG-1] !== 1'b1 || q_last[0] !== 1'b0 || q_last[1] !== 1'b0) begin
        n_fail++; $display("FAIL rand_last[%0d]: got %p, required only final consume flagged", s, q_last);
      end
    end
  endtask

  initial begin
    test_reset();
    test_qpsk_timing();
    test_qam64();
    test_pad();
    test_stall();
    test_err();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
